// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - pipelined sign-magnitude multiplier with scaling, rounding and saturation
module mult_pipe #(
  parameter int N1    = 24,
  parameter int N2    = 16,
  parameter int N_RES = 32,
  parameter int S1    = 0,
  parameter int SHIFT = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N1-1:0]    mn1,
  input  logic [N2-1:0]    mn2,
  input  logic             rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_RES-1:0] result,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  localparam int M1 = N1 - S1;
  localparam int M2 = N2 - 1;
  localparam int PW = M1 + M2;
  localparam int MW = N_RES - 1;
  // Scaled product width: one spare bit so the rounding increment cannot wrap.
  localparam int QW = PW - SHIFT + 1;

  // Stage 1: operand magnitudes, result sign, rounding mode
  logic          st1_vld_q, st1_vld_d;
  logic [M1-1:0] st1_mag1_q, st1_mag1_d;
  logic [M2-1:0] st1_mag2_q, st1_mag2_d;
  logic          st1_sgn_q, st1_sgn_d;
  logic          st1_rnd_q, st1_rnd_d;

  // Stage 2: full-width magnitude product
  logic          st2_vld_q, st2_vld_d;
  logic [PW-1:0] st2_prod_q, st2_prod_d;
  logic          st2_sgn_q, st2_sgn_d;
  logic          st2_rnd_q, st2_rnd_d;

  // Stage 3: delivered result
  logic             out_vld_q, out_vld_d;
  logic [N_RES-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Whole pipeline advances only when the output register is free or being drained.
  logic en;
  assign en       = ~out_vld_q | out_ready;
  assign in_ready = en;

  // Stage-3 datapath: scale, optional round-half-up, saturate, sign fix-up
  logic [QW-1:0] q_trunc;
  logic [QW-1:0] q_sum;
  logic          rnd_bit;
  logic          sat_c;
  logic [MW-1:0] mag_c;
  logic          sgn_c;

  assign q_trunc = QW'(st2_prod_q >> SHIFT);

  generate
    if (SHIFT > 0) begin : g_rnd
      assign rnd_bit = st2_rnd_q & st2_prod_q[SHIFT-1];
    end else begin : g_no_rnd
      assign rnd_bit = 1'b0;
    end
  endgenerate

  assign q_sum = q_trunc + QW'(rnd_bit);

  generate
    if (QW > MW) begin : g_sat
      assign sat_c = |q_sum[QW-1:MW];
      assign mag_c = sat_c ? {MW{1'b1}} : q_sum[MW-1:0];
    end else if (QW == MW) begin : g_fit
      assign sat_c = 1'b0;
      assign mag_c = q_sum;
    end else begin : g_ext
      assign sat_c = 1'b0;
      assign mag_c = {{(MW-QW){1'b0}}, q_sum};
    end
  endgenerate

  // A zero magnitude always carries a positive sign.
  assign sgn_c = st2_sgn_q & (|mag_c);

  // Next-state values for every pipeline stage
  always_comb begin
    st1_vld_d  = in_valid;
    st1_mag1_d = mn1[M1-1:0];
    st1_mag2_d = mn2[M2-1:0];
    st1_sgn_d  = mn2[N2-1] ^ ((S1 != 0) && mn1[N1-1]);
    st1_rnd_d  = rnd;

    st2_vld_d  = st1_vld_q;
    st2_prod_d = {{M2{1'b0}}, st1_mag1_q} * {{M1{1'b0}}, st1_mag2_q};
    st2_sgn_d  = st1_sgn_q;
    st2_rnd_d  = st1_rnd_q;

    out_vld_d  = st2_vld_q;
    res_d      = {sgn_c, mag_c};
    ovf_d      = sat_c;
  end

  // Pipeline registers: all stages hold together while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_vld_q  <= 1'b0;
      st1_mag1_q <= '0;
      st1_mag2_q <= '0;
      st1_sgn_q  <= 1'b0;
      st1_rnd_q  <= 1'b0;
      st2_vld_q  <= 1'b0;
      st2_prod_q <= '0;
      st2_sgn_q  <= 1'b0;
      st2_rnd_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (en) begin
      st1_vld_q  <= st1_vld_d;
      st1_mag1_q <= st1_mag1_d;
      st1_mag2_q <= st1_mag2_d;
      st1_sgn_q  <= st1_sgn_d;
      st1_rnd_q  <= st1_rnd_d;
      st2_vld_q  <= st2_vld_d;
      st2_prod_q <= st2_prod_d;
      st2_sgn_q  <= st2_sgn_d;
      st2_rnd_q  <= st2_rnd_d;
      out_vld_q  <= out_vld_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
    end
  end

  // Overflow counter next state: clear wins, increment sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_vld_q && out_ready && ovf_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Overflow counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = out_vld_q;
  assign result    = res_q;
  assign ovf       = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_mult_pipe.sv
// tb/tb_mult_pipe.sv - scoreboard bench for mult_pipe (default, CNT_W=2 and S1=1 instances)
module tb_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] mn1;
  logic [15:0] mn2;
  logic        rnd;
  logic        out_ready;
  logic        cnt_clr;

  logic        a_in_ready, a_out_valid, a_ovf;
  logic [31:0] a_result;
  logic [15:0] a_ovf_cnt;
  logic        b_in_ready, b_out_valid, b_ovf;
  logic [31:0] b_result;
  logic [1:0]  b_ovf_cnt;
  logic        c_in_ready, c_out_valid, c_ovf;
  logic [31:0] c_result;
  logic [15:0] c_ovf_cnt;

  mult_pipe u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .mn1(mn1), .mn2(mn2), .rnd(rnd), .out_valid(a_out_valid), .out_ready(out_ready),
    .result(a_result), .ovf(a_ovf), .ovf_cnt(a_ovf_cnt), .cnt_clr(cnt_clr)
  );

  mult_pipe #(.CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .mn1(mn1), .mn2(mn2), .rnd(rnd), .out_valid(b_out_valid), .out_ready(out_ready),
    .result(b_result), .ovf(b_ovf), .ovf_cnt(b_ovf_cnt), .cnt_clr(cnt_clr)
  );

  mult_pipe #(.S1(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .mn1(mn1), .mn2(mn2), .rnd(rnd), .out_valid(c_out_valid), .out_ready(out_ready),
    .result(c_result), .ovf(c_ovf), .ovf_cnt(c_ovf_cnt), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ra;
    logic        oa;
    logic [31:0] rc;
    logic        oc;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_pops   = 0;
  int          cnt_a    = 0;
  int          cnt_b    = 0;
  bit          chk_lat  = 1;
  logic [31:0] last_ra, last_rc;
  logic        last_oa;

  // Reference: wide integer arithmetic straight from the behavioural description (SHIFT=7, N_RES=32)
  function automatic logic [32:0] model(input logic [23:0] a, input logic [15:0] b,
                                        input logic r, input bit s1);
    longint unsigned m1, m2, p, q;
    logic sg, ov;
    m1 = s1 ? 64'(a[22:0]) : 64'(a);
    m2 = 64'(b[14:0]);
    sg = b[15] ^ (s1 & a[23]);
    p  = m1 * m2;
    q  = p >> 7;
    if (r) q = q + ((p >> 6) & 64'd1);
    ov = (q > 64'h7FFF_FFFF);
    if (ov) q = 64'h7FFF_FFFF;
    if (q == 0) sg = 1'b0;
    return {ov, sg, q[30:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the current cycle, advance, then check the counters.
  task automatic step();
    exp_t        e;
    logic [32:0] ma, mc;
    logic        acc, xfer;
    #1;
    chk("in_ready_rule", 64'(a_in_ready), 64'(!a_out_valid || out_ready));
    acc  = in_valid && a_in_ready;
    xfer = a_out_valid && out_ready;
    if (acc) begin
      ma = model(mn1, mn2, rnd, 1'b0);
      mc = model(mn1, mn2, rnd, 1'b1);
      e.ra = ma[31:0]; e.oa = ma[32]; e.rc = mc[31:0]; e.oc = mc[32];
      e.cyc = cyc; e.lat = chk_lat;
      sb.push_back(e);
    end
    if (xfer) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(a_out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        n_pops++;
        chk("result_a", 64'(a_result), 64'(e.ra));
        chk("ovf_a", 64'(a_ovf), 64'(e.oa));
        chk("result_c", 64'(c_result), 64'(e.rc));
        chk("ovf_c", 64'(c_ovf), 64'(e.oc));
        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
        last_ra = a_result; last_oa = a_ovf; last_rc = c_result;
        if (e.oa && !cnt_clr) begin
          if (cnt_a < 65535) cnt_a++;
          if (cnt_b < 3) cnt_b++;
        end
      end
    end
    if (cnt_clr) begin
      cnt_a = 0;
      cnt_b = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("ovf_cnt_a", 64'(a_ovf_cnt), 64'(cnt_a));
    chk("ovf_cnt_b", 64'(b_ovf_cnt), 64'(cnt_b));
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_one(input logic [23:0] a, input logic [15:0] b, input logic r,
                           input logic [31:0] exp_res, input logic exp_ovf);
    mn1 = a; mn2 = b; rnd = r; in_valid = 1'b1;
    last_ra = 32'hDEAD_BEEF; last_oa = 1'bx;
    step();
    drain();
    chk("lit_result", 64'(last_ra), 64'(exp_res));
    chk("lit_ovf", 64'(last_oa), 64'(exp_ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx, sn, p0, nw;
    bit          held;
    logic [31:0] hold_res;

    rst_n = 1'b0; in_valid = 1'b0; mn1 = '0; mn2 = '0; rnd = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_result", 64'(a_result), 64'd0);
    chk("rst_ovf", 64'(a_ovf), 64'd0);
    chk("rst_ovf_cnt", 64'(a_ovf_cnt), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    rst_n = 1'b1;

    // Basic products, sign handling
    check_one(24'h800000, 16'h4000, 1'b0, 32'h4000_0000, 1'b0);
    check_one(24'h800000, 16'hC000, 1'b0, 32'hC000_0000, 1'b0);
    // Saturation
    check_one(24'hFFFFFF, 16'h7FFF, 1'b0, 32'h7FFF_FFFF, 1'b1);
    chk("ovf_cnt_one", 64'(a_ovf_cnt), 64'd1);
    check_one(24'hFFFFFF, 16'hFFFF, 1'b0, 32'hFFFF_FFFF, 1'b1);
    // Rounding and negative zero
    check_one(24'h000001, 16'h0040, 1'b0, 32'h0000_0000, 1'b0);
    check_one(24'h000001, 16'h0040, 1'b1, 32'h0000_0001, 1'b0);
    check_one(24'h000001, 16'h8040, 1'b0, 32'h0000_0000, 1'b0);
    check_one(24'h000001, 16'h8040, 1'b1, 32'h8000_0001, 1'b0);
    // Signed operand 1 on the S1=1 instance
    check_one(24'h800002, 16'h8080, 1'b0, 32'h8080_0002, 1'b0);
    chk("s1_result", 64'(last_rc), 64'h0000_0002);

    // cnt_clr coincident with a saturated transfer
    chk("ovf_cnt_pre_clr", 64'(a_ovf_cnt), 64'd2);
    mn1 = 24'hFFFFFF; mn2 = 16'h7FFF; rnd = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    nw = 0;
    while (!a_out_valid && nw < 10) begin
      step();
      nw++;
    end
    chk("clr_wait", 64'(a_out_valid), 64'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("ovf_cnt_clr", 64'(a_ovf_cnt), 64'd0);
    drain();

    // Five saturated results: 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) begin
      mn1 = 24'hFFFFFF - 24'(i); mn2 = 16'h7FFF; in_valid = 1'b1;
      step();
    end
    drain();
    chk("cnt_b_sat", 64'(b_ovf_cnt), 64'd3);
    chk("cnt_a_five", 64'(a_ovf_cnt), 64'd5);

    // Eight back-to-back operands with a downstream stall
    chk_lat = 0;
    idx = 0; sn = 0; p0 = n_pops;
    while ((idx < 8 || sb.size() > 0) && sn < 40) begin
      out_ready = !(sn >= 4 && sn <= 7);
      if (idx < 8) begin
        in_valid = 1'b1;
        mn1 = 24'(idx * 24'h01F3A5 + 5);
        mn2 = {idx[0], 15'(idx * 1234 + 7)};
        rnd = idx[1];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      held = a_out_valid && !out_ready;
      hold_res = a_result;
      if (held) chk("stall_in_ready", 64'(a_in_ready), 64'd0);
      if (in_valid && a_in_ready) idx++;
      step();
      if (held) begin
        chk("stall_result", 64'(a_result), 64'(hold_res));
        chk("stall_valid", 64'(a_out_valid), 64'd1);
      end
      sn++;
    end
    out_ready = 1'b1;
    chk("stream_count", 64'(n_pops - p0), 64'd8);
    chk("stream_left", 64'(sb.size()), 64'd0);
    chk_lat = 1;

    // Asynchronous reset with three results in flight
    for (int i = 0; i < 3; i++) begin
      mn1 = 24'h400000 + 24'(i); mn2 = 16'h2000; rnd = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2;
    chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(a_out_valid), 64'd0);
    chk("arst_result", 64'(a_result), 64'd0);
    chk("arst_ovf", 64'(a_ovf), 64'd0);
    chk("arst_cnt", 64'(a_ovf_cnt), 64'd0);
    sb.delete();
    cnt_a = 0; cnt_b = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    chk("no_stale_valid", 64'(a_out_valid), 64'd0);
    check_one(24'h800000, 16'h4000, 1'b0, 32'h4000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Parametrised, pipelined sign-magnitude multiplier; next generation of the datapath multiplier.
- Adds the following over the existing multiplier:
  - an optional sign on operand 1, with the result sign equal to the XOR of both operand signs;
  - a configurable binary-point shift;
  - selectable truncate or round-half-up;
  - magnitude saturation with an overflow flag and a counter;
  - valid/ready flow control with full-pipeline stall.
- Sits between sample sources and accumulator/filter stages in the FP datapath.

Parameters:
- N1, 24, width of mn1.
- N2, 16, width of mn2; MSB is the sign.
- N_RES, 32, width of result; MSB is the sign.
- S1, 0, 1 means mn1 MSB is a sign bit; 0 means mn1 is an unsigned magnitude.
- SHIFT, 7, product bit index that maps to result LSB; legal range 0..PW-1.
- CNT_W, 16, width of ovf_cnt.
- Derived: M1=N1-S1, M2=N2-1, PW=M1+M2, MW=N_RES-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- mn1  in  N1  operand 1.
- mn2  in  N2  operand 2, sign-magnitude.
- rnd  in  1  0 = truncate, 1 = round half up; sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  N_RES  sign-magnitude product.
- ovf  out  1  saturation occurred for the current result; qualified by out_valid.
- ovf_cnt  out  CNT_W  count of saturated results delivered.
- cnt_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous) clears, immediately: all stage valid bits, out_valid=0, result=0, ovf=0, ovf_cnt=0. Operands in flight are discarded.
- Pipeline has 3 stages:
  - S1 registers magnitudes, sign s = mn2[N2-1] XOR (S1 ? mn1[N1-1] : 0), and rnd.
  - S2 computes the PW-bit product P = mag1*mag2.
  - S3 scales, rounds, saturates and drives result, ovf and out_valid.
- Latency: 3 cycles from the accepting edge to out_valid, when not stalled. Throughput is 1 per cycle.
- Flow control:
  - en = !out_valid | out_ready; in_ready = en (combinational).
  - When en=0 every stage holds.
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - Bubbles are not collapsed.
  - result, ovf and out_valid are stable while out_valid=1 and out_ready=0.
- Scaling and rounding:
  - Q = P >> SHIFT, computed at PW-SHIFT+1 bits.
  - If rnd=1 and SHIFT>0, Q = Q + P[SHIFT-1]. If SHIFT=0, rnd has no effect.
- Saturation: if Q > 2^MW-1, the magnitude becomes 2^MW-1 and ovf=1. Otherwise the magnitude is Q[MW-1:0] and ovf=0. An overflow caused by the rounding increment also saturates.
- Sign: result[N_RES-1] = s, except it is forced to 0 when the output magnitude is 0. The block never emits negative zero.
- ovf_cnt:
  - Increments on each output transfer (out_valid & out_ready) that has ovf=1.
  - Saturates at 2^CNT_W-1; never wraps.
  - cnt_clr has priority over an increment in the same cycle.
- Reset deasserting mid-stream: the first accepted operand after release produces the first out_valid 3 cycles later.

Test Plan:
- Defaults, rnd=0, out_ready=1; mn1=24'h800000, mn2=16'h4000 -> result=32'h4000_0000 exactly 3 cycles after acceptance, ovf=0. Repeat with mn2=16'hC000 -> 32'hC000_0000.
- mn1=24'hFFFFFF, mn2=16'h7FFF -> result=32'h7FFF_FFFF, ovf=1, ovf_cnt increments to 1. Same operands with mn2=16'hFFFF -> 32'hFFFF_FFFF.
- mn1=24'h000001, mn2=16'h0040: rnd=0 -> 32'h0000_0000; rnd=1 -> 32'h0000_0001. mn2=16'h8040 with rnd=0 -> 32'h0000_0000 (no negative zero).
- Stream of 8 back-to-back operand pairs with out_ready held low for cycles 4..7:
  - in_ready drops while out_valid=1 and out_ready=0;
  - result is stable throughout the stall;
  - all 8 results arrive in order, none lost or duplicated.
- ovf_cnt behaviour:
  - cnt_clr pulsed in the same cycle as a saturated transfer -> ovf_cnt=0.
  - With CNT_W=2, five saturated results -> ovf_cnt holds at 3.
- rst_n pulsed low with 3 results in flight -> out_valid=0 and result=0 asynchronously; no stale result appears after release.
- S1=1, mn1=24'h800002 (value -2), mn2=16'h8080 -> sign 0, magnitude=(2*128)>>7=2, result=32'h0000_0002.
